uart_frame_ctrl: RTL and testbench
==================================

// Module: uart_frame_ctrl
// PURPOSE
//  Sequencer between the UART pair (async_receiver / async_transmitter) and a
//  frame-processing core (e.g. decoder_sys). Gathers NBYTES received bytes into
//  a frame and launches the core. It then captures the core result and
//  serialises RESP_BYTES back out through the transmitter with busy handshaking.
//  Replaces ad-hoc byte counting and button-driven TX in top-level glue.
// PARAMETERS
//  NBYTES      4           bytes per inbound frame (1..16)
//  RESP_BYTES  4           bytes per outbound response (1..16)
//  GAP_CYCLES  1_000_000   max clk cycles between bytes of one frame (10 ms @100 MHz)
// PORTS
//  clk          in   1             system clock, all logic on rising edge
//  rst          in   1             asynchronous, active-high reset
//  clr          in   1             sync abort (debounced button), 1-cycle pulse
//  rx_ready     in   1             async_receiver RxD_data_ready, 1-cycle pulse
//  rx_data      in   8             async_receiver RxD_data, valid with rx_ready
//  core_frame   out  8*NBYTES      assembled frame, byte0 in [7:0]
//  core_start   out  1             1-cycle launch pulse to core
//  core_done    in   1             core result valid, 1-cycle pulse
//  core_result  in   8*RESP_BYTES  result, sampled when core_done=1; byte0 in [7:0]
//  tx_busy      in   1             async_transmitter TxD_busy
//  tx_start     out  1             1-cycle pulse to async_transmitter TxD_start
//  tx_data      out  8             byte to send, stable from tx_start until tx_busy falls
//  busy         out  1             1 in any state other than IDLE
//  frame_err    out  1             1-cycle pulse: gap timeout or byte dropped
// BEHAVIOUR
//  Reset (async): state=IDLE; byte_cnt=0; gap_cnt=0; core_frame=0; tx_data=0;
//    all pulse outputs=0; busy=0; result register=0.
//  States: IDLE, RECV, LAUNCH, WAIT_CORE, SEND, GUARD, DRAIN.
//  IDLE: rx_ready -> store byte at index 0, byte_cnt=1, gap_cnt=0.
//    NBYTES==1 -> LAUNCH; otherwise -> RECV.
//  RECV: rx_ready -> store at index byte_cnt, byte_cnt++, gap_cnt=0.
//    Storing the last byte -> LAUNCH. No rx_ready -> gap_cnt++.
//    gap_cnt==GAP_CYCLES-1 -> frame_err pulse, byte_cnt=0, -> IDLE.
//    Partial bytes already written to core_frame are not cleared.
//  LAUNCH: core_start=1 for exactly this cycle; core_frame frozen -> WAIT_CORE.
//  WAIT_CORE: core_done -> latch core_result, idx=0 -> SEND. No timeout.
//    core_done in any other state is ignored.
//  SEND: if !tx_busy: tx_data=result byte idx, tx_start=1 (1 cycle) -> GUARD;
//    otherwise hold.
//  GUARD: 1 cycle; tx_busy is ignored, to cover transmitter busy latency -> DRAIN.
//  DRAIN: tx_busy==0 -> idx++. If idx was RESP_BYTES-1 -> IDLE, otherwise -> SEND.
//  Dropped bytes: rx_ready in LAUNCH/WAIT_CORE/SEND/GUARD/DRAIN -> byte discarded,
//    frame_err pulse. No buffering while a frame is in flight.
//  clr: in any state -> IDLE next cycle; byte_cnt=0, idx=0, no pulses issued.
//    Takes priority over rx_ready in the same cycle, and the byte is discarded.
//    Any TX byte already started completes inside the transmitter.
//  Counter widths: byte_cnt and idx use $clog2(max(N,2))+1 bits; gap_cnt uses
//    $clog2(GAP_CYCLES)+1 bits. All counters saturate and never wrap.
//  Latency: last rx_ready -> core_start = 2 cycles. core_done -> first
//    tx_start = 2 cycles when tx_busy is low.
//  rst mid-operation: immediate IDLE; core may still pulse core_done later,
//    and that pulse is ignored.
// TESTING
//  1 Bytes 11,22,33,44 spaced 10 cycles -> core_frame=32'h44332211, one core_start.
//  2 core_done with result 32'hDDCCBBAA, tx_busy modelled as 20-cycle busy ->
//    tx_start x4 with tx_data AA,BB,CC,DD in order, none while busy; then busy=0.
//  3 Two bytes, then silence of GAP_CYCLES (set GAP_CYCLES=50) -> frame_err on
//    cycle 50 after the last byte, back to IDLE; next 4 bytes form a clean frame.
//  4 rx_ready during WAIT_CORE -> frame_err pulse, core_frame unchanged, no 2nd start.
//  5 clr asserted mid-RECV with rx_ready in the same cycle -> IDLE, byte dropped,
//    no frame_err; clr during SEND -> no further tx_start.
//  6 rst pulse during DRAIN -> all outputs at reset values within 1 cycle
//    asynchronously; a subsequent core_done is ignored.

Source files
------------

// File: rtl/uart_frame_ctrl.sv
// Sequencer between a UART receiver/transmitter pair and a frame-processing core.
// Assembles NBYTES inbound bytes into a frame, launches the core and streams the result back out.
module uart_frame_ctrl #(
   parameter int NBYTES     = 4,
   parameter int RESP_BYTES = 4,
   parameter int GAP_CYCLES = 1_000_000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clr,
   input  logic                      rx_ready,
   input  logic [7:0]                rx_data,
   output logic [8*NBYTES-1:0]       core_frame,
   output logic                      core_start,
   input  logic                      core_done,
   input  logic [8*RESP_BYTES-1:0]   core_result,
   input  logic                      tx_busy,
   output logic                      tx_start,
   output logic [7:0]                tx_data,
   output logic                      busy,
   output logic                      frame_err
);

   localparam int BC_W  = $clog2((NBYTES < 2) ? 2 : NBYTES) + 1;
   localparam int IDX_W = $clog2((RESP_BYTES < 2) ? 2 : RESP_BYTES) + 1;
   localparam int GAP_W = $clog2(GAP_CYCLES) + 1;

   localparam logic [BC_W-1:0]  LAST_BYTE = BC_W'(NBYTES - 1);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(RESP_BYTES - 1);
   localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, RECV, LAUNCH, WAIT_CORE, SEND, GUARD, DRAIN} state_t;

   state_t                    state;
   logic [BC_W-1:0]           byte_cnt;
   logic [IDX_W-1:0]          idx;
   logic [GAP_W-1:0]          gap_cnt;
   logic [8*RESP_BYTES-1:0]   result;

   assign busy = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         byte_cnt   <= '0;
         idx        <= '0;
         gap_cnt    <= '0;
         core_frame <= '0;
         result     <= '0;
         tx_data    <= '0;
         core_start <= 1'b0;
         tx_start   <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         core_start <= 1'b0;
         tx_start   <= 1'b0;
         frame_err  <= 1'b0;
         if (clr) begin
            // Abort wins over everything, including a byte arriving this cycle.
            state    <= IDLE;
            byte_cnt <= '0;
            idx      <= '0;
            gap_cnt  <= '0;
         end else begin
            if (rx_ready && state != IDLE && state != RECV)
               frame_err <= 1'b1;
            case (state)
               IDLE: begin
                  if (rx_ready) begin
                     core_frame[7:0] <= rx_data;
                     byte_cnt        <= BC_W'(1);
                     gap_cnt         <= '0;
                     if (NBYTES == 1) state <= LAUNCH;
                     else             state <= RECV;
                  end
               end
               RECV: begin
                  if (rx_ready) begin
                     for (int i = 0; i < NBYTES; i++)
                        if (byte_cnt == BC_W'(i)) core_frame[i*8 +: 8] <= rx_data;
                     if (byte_cnt != '1) byte_cnt <= byte_cnt + 1'b1;
                     gap_cnt <= '0;
                     if (byte_cnt == LAST_BYTE) state <= LAUNCH;
                  end else if (gap_cnt == GAP_LAST) begin
                     frame_err <= 1'b1;
                     byte_cnt  <= '0;
                     gap_cnt   <= '0;
                     state     <= IDLE;
                  end else if (gap_cnt != '1) begin
                     gap_cnt <= gap_cnt + 1'b1;
                  end
               end
               LAUNCH: begin
                  core_start <= 1'b1;
                  byte_cnt   <= '0;
                  state      <= WAIT_CORE;
               end
               WAIT_CORE: begin
                  if (core_done) begin
                     result <= core_result;
                     idx    <= '0;
                     state  <= SEND;
                  end
               end
               SEND: begin
                  if (!tx_busy) begin
                     for (int i = 0; i < RESP_BYTES; i++)
                        if (idx == IDX_W'(i)) tx_data <= result[i*8 +: 8];
                     tx_start <= 1'b1;
                     state    <= GUARD;
                  end
               end
               // Transmitter raises busy a cycle late; skip one cycle before trusting it.
               GUARD: state <= DRAIN;
               DRAIN: begin
                  if (!tx_busy) begin
                     if (idx == LAST_IDX) begin
                        state <= IDLE;
                     end else begin
                        if (idx != '1) idx <= idx + 1'b1;
                        state <= SEND;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Scoreboard bench for uart_frame_ctrl: stimulus pushes expected launches, TX bytes
// and error pulses (with their clock period) into queues; a monitor pops and compares.
module tb_uart_frame_ctrl;

   localparam int NB  = 4;
   localparam int RB  = 4;
   localparam int GAP = 50;

   logic          clk = 1'b0;
   logic          rst, clr, rx_ready, core_done, tx_busy;
   logic [7:0]    rx_data;
   logic [31:0]   core_frame, core_result;
   logic          core_start, tx_start, busy, frame_err;
   logic [7:0]    tx_data;

   uart_frame_ctrl #(.NBYTES(NB), .RESP_BYTES(RB), .GAP_CYCLES(GAP)) dut (
      .clk(clk), .rst(rst), .clr(clr), .rx_ready(rx_ready), .rx_data(rx_data),
      .core_frame(core_frame), .core_start(core_start), .core_done(core_done),
      .core_result(core_result), .tx_busy(tx_busy), .tx_start(tx_start),
      .tx_data(tx_data), .busy(busy), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   typedef struct { longint per; logic [31:0] val; } exp_t;
   exp_t start_q[$];
   exp_t tx_q[$];
   exp_t err_q[$];

   int     checks = 0;
   int     errors = 0;
   longint cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Transmitter model: busy for busy_len cycles after each start.
   int   busy_left = 0;
   int   busy_len  = 20;
   logic busy_hold = 1'b0;
   always @(posedge clk) begin
      if (tx_start)           busy_left <= busy_len;
      else if (busy_left > 0) busy_left <= busy_left - 1;
   end
   assign tx_busy = (busy_left > 0) || busy_hold;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   logic [7:0] held;
   logic       held_vld = 1'b0;
   always @(posedge rst) held_vld = 1'b0;

   always @(negedge clk) begin
      exp_t   e;
      longint p;
      if (!rst) begin
         p = cyc + 1;
         if (tx_busy && held_vld) chk("tx_data_stable", {56'd0, tx_data}, {56'd0, held});
         if (core_start) begin
            if (start_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL core_start unexpected at period %0d frame=%h", p, core_frame);
            end else begin
               e = start_q.pop_front();
               chk("start_period", p, e.per);
               chk("core_frame", {32'd0, core_frame}, {32'd0, e.val});
            end
         end
         if (tx_start) begin
            chk("tx_start_not_busy", {63'd0, tx_busy}, 64'd0);
            held = tx_data;
            held_vld = 1'b1;
            if (tx_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL tx_start unexpected at period %0d data=%h", p, tx_data);
            end else begin
               e = tx_q.pop_front();
               chk("tx_data", {56'd0, tx_data}, {32'd0, e.val});
               if (e.per >= 0) chk("tx_period", p, e.per);
            end
         end
         if (frame_err) begin
            if (err_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL frame_err unexpected at period %0d", p);
            end else begin
               e = err_q.pop_front();
               chk("err_period", p, e.per);
            end
         end
      end
   end

   // All tasks begin and end just after a falling edge; per = period being driven.
   task automatic send_bytes(input int n, input logic [31:0] f, input int gap,
                             input bit expect_start, output longint last_per);
      for (int i = 0; i < n; i++) begin
         rx_ready = 1'b1;
         rx_data  = f[8*i +: 8];
         last_per = cyc + 1;
         if (expect_start && i == n - 1) start_q.push_back('{last_per + 2, f});
         @(negedge clk);
         rx_ready = 1'b0;
         rx_data  = 8'($urandom);
         repeat (gap) @(negedge clk);
      end
   endtask

   task automatic respond(input logic [31:0] r, input int blen, input int nexp);
      longint p;
      busy_len    = blen;
      core_done   = 1'b1;
      core_result = r;
      p = cyc + 1;
      for (int i = 0; i < nexp; i++)
         tx_q.push_back('{(i == 0) ? p + 2 : -1, {24'd0, r[8*i +: 8]}});
      @(negedge clk);
      core_done   = 1'b0;
      core_result = $urandom;
   endtask

   task automatic wait_q(input int budget, input bit need_idle);
      int n = 0;
      while ((start_q.size() + tx_q.size() + err_q.size() != 0 || (need_idle && busy)) && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= budget) begin
         errors++;
         $display("FAIL wait_timeout pending start=%0d tx=%0d err=%0d busy=%0d required all 0",
                  start_q.size(), tx_q.size(), err_q.size(), busy);
         start_q.delete(); tx_q.delete(); err_q.delete();
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] f, r;
      longint      lp;
      rst = 1'b1; clr = 1'b0; rx_ready = 1'b0; rx_data = 8'd0;
      core_done = 1'b0; core_result = 32'd0;
      repeat (3) @(negedge clk);
      chk("rst_busy",       {63'd0, busy}, 64'd0);
      chk("rst_core_start", {63'd0, core_start}, 64'd0);
      chk("rst_tx_start",   {63'd0, tx_start}, 64'd0);
      chk("rst_frame_err",  {63'd0, frame_err}, 64'd0);
      chk("rst_core_frame", {32'd0, core_frame}, 64'd0);
      chk("rst_tx_data",    {56'd0, tx_data}, 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // Directed frame and response with a 20-cycle transmitter
      send_bytes(4, 32'h44332211, 10, 1'b1, lp);
      wait_q(100, 1'b0);
      respond(32'hDDCCBBAA, 20, 4);
      wait_q(1000, 1'b1);
      chk("idle_after_resp", {63'd0, busy}, 64'd0);

      // Gap timeout after two bytes, then a clean frame
      f = $urandom;
      send_bytes(2, f, 3, 1'b0, lp);
      err_q.push_back('{lp + 1 + GAP, 32'd0});
      wait_q(200, 1'b1);
      chk("idle_after_gap", {63'd0, busy}, 64'd0);
      f = $urandom;
      send_bytes(4, f, 1, 1'b1, lp);
      wait_q(100, 1'b0);

      // Byte arriving while the core is busy is dropped
      rx_ready = 1'b1;
      rx_data  = ~f[7:0];
      err_q.push_back('{cyc + 2, 32'd0});
      @(negedge clk);
      rx_ready = 1'b0;
      wait_q(20, 1'b0);
      chk("frame_kept", {32'd0, core_frame}, {32'd0, f});
      repeat (5) @(negedge clk);
      respond($urandom, 3, 4);
      wait_q(500, 1'b1);

      // clr together with rx_ready mid-frame: silent abort
      f = $urandom;
      send_bytes(2, f, 2, 1'b0, lp);
      clr = 1'b1; rx_ready = 1'b1; rx_data = 8'h5A;
      @(negedge clk);
      clr = 1'b0; rx_ready = 1'b0;
      @(negedge clk);
      chk("idle_after_clr", {63'd0, busy}, 64'd0);
      f = $urandom;
      send_bytes(4, f, 0, 1'b1, lp);
      wait_q(100, 1'b0);

      // clr while SEND is held off by a busy transmitter: nothing is sent
      busy_hold = 1'b1;
      respond($urandom, 20, 0);
      repeat (5) @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      busy_hold = 1'b0;
      repeat (40) @(negedge clk);
      chk("idle_after_clr_send", {63'd0, busy}, 64'd0);

      // Asynchronous reset while draining, then a stray core_done
      f = $urandom;
      send_bytes(4, f, 2, 1'b1, lp);
      wait_q(100, 1'b0);
      respond(32'h0F1E2D3C, 20, 1);
      wait_q(50, 1'b0);
      repeat (4) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_busy",       {63'd0, busy}, 64'd0);
      chk("arst_core_start", {63'd0, core_start}, 64'd0);
      chk("arst_tx_start",   {63'd0, tx_start}, 64'd0);
      chk("arst_frame_err",  {63'd0, frame_err}, 64'd0);
      chk("arst_core_frame", {32'd0, core_frame}, 64'd0);
      chk("arst_tx_data",    {56'd0, tx_data}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      respond($urandom, 20, 0);
      repeat (60) @(negedge clk);
      chk("idle_after_arst", {63'd0, busy}, 64'd0);

      // Randomised frames and responses
      for (int k = 0; k < 6; k++) begin
         f = $urandom;
         send_bytes(4, f, $urandom_range(0, 5), 1'b1, lp);
         wait_q(200, 1'b0);
         repeat ($urandom_range(0, 4)) @(negedge clk);
         r = $urandom;
         respond(r, $urandom_range(1, 25), 4);
         wait_q(1000, 1'b1);
      end
      chk("final_idle", {63'd0, busy}, 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
